// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receive front end.
//
// Deserialises frames arriving on an idle-high serial line, sampling each bit
// at its midpoint. A good frame (stop bit = 1) updates rxdata and pulses
// dataValidRX for one cycle. A bad stop bit raises the sticky frame_err flag
// and parks the receiver until the line returns high, so a held-low line
// (break) yields a single error rather than a stream of bogus bytes.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   rx           asynchronous serial input, idle high
//   rxdata       last correctly framed byte, LSB received first
//   dataValidRX  one-cycle strobe when rxdata is updated
//   frame_err    sticky; set on a 0 stop bit, cleared by the next good frame
//   busy         high whenever the receiver is not idle
//
// CLK_HZ / BAUD must give at least 4 clocks per bit.
module uart_rx #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rxdata,
    output logic       dataValidRX,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

    // Counter values at which a sample is taken; a period of N cycles ends when
    // the counter reads N-1.
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    logic [1:0]      sync_q;
    logic            rx_s;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rxdata_q, rxdata_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Two-flop synchroniser; reset to the idle level so reset never looks
    // like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            rxdata_q <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            rxdata_q <= rxdata_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        rxdata_d = rxdata_q;
        valid_d  = 1'b0;
        ferr_d   = ferr_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end

            // Re-check the line at mid start bit to reject short glitches.
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            // Leaving at mid stop bit lets a back-to-back start edge be caught.
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rxdata_d = shift_q;
                        valid_d  = 1'b1;
                        ferr_d   = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StBreak: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign rxdata      = rxdata_q;
    assign dataValidRX = valid_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit. Each driven good frame pushes its
// byte and the cycle its strobe must appear in onto a scoreboard; a negedge
// monitor pops and compares, and flags any strobe nobody expected.
module tb_uart_rx;

    localparam int unsigned Cpb = 16;
    localparam int unsigned Half = 8;
    // Pin edge -> two synchroniser flops -> FSM sees it (3), then start and
    // data/stop sampling.
    localparam int Lat = 3 + Half + 9 * Cpb;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rxdata;
    logic       dataValidRX;
    logic       frame_err;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    uart_rx #(
        .CLK_HZ(1600),
        .BAUD  (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rxdata     (rxdata),
        .dataValidRX(dataValidRX),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance n edges, then settle just past the edge before driving/sampling.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_ok,
                              input bit chk_busy);
        exp_t e;
        if (expect_ok) begin
            e.data = d;
            e.cyc  = cyc + Lat;
            sb.push_back(e);
        end
        rx = 1'b0;
        if (chk_busy) begin
            tick(2);
            check("busy_before_t0", busy, 1'b0);
            tick(1);
            check("busy_after_t0", busy, 1'b1);
            tick(Cpb - 3);
        end else begin
            tick(Cpb);
        end
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(Cpb);
        end
        rx = stop_bit;
        tick(Cpb);
    endtask

    // Scoreboard monitor: every expected strobe must land on its exact cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && cyc == sb[0].cyc) begin
                check("strobe", dataValidRX, 1'b1);
                check("strobe_data", rxdata, sb[0].data);
                check("busy_at_strobe", busy, 1'b0);
                check("ferr_at_strobe", frame_err, 1'b0);
                void'(sb.pop_front());
            end else if (dataValidRX) begin
                check("unexpected_strobe", dataValidRX, 1'b0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        check("rst_rxdata", rxdata, 8'h00);
        check("rst_valid", dataValidRX, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(10);

        // Single frame, code 20.
        send_frame(8'h14, 1'b1, 1'b1, 1'b1);
        tick(20);
        check("single_rxdata", rxdata, 8'h14);
        check("single_ferr", frame_err, 1'b0);
        tick(1000);
        check("single_hold", rxdata, 8'h14);

        // Glitch shorter than half a bit.
        rx = 1'b0;
        tick(4);
        check("glitch_busy_start", busy, 1'b1);
        rx = 1'b1;
        tick(20);
        check("glitch_busy_idle", busy, 1'b0);
        check("glitch_rxdata", rxdata, 8'h14);

        // Back-to-back frames, no idle gap.
        send_frame(8'h15, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1A, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        tick(40);
        check("b2b_rxdata", rxdata, 8'h00);

        // Framing error followed by a held-low line.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        tick(100);
        check("ferr_set", frame_err, 1'b1);
        check("ferr_break_busy", busy, 1'b1);
        check("ferr_rxdata", rxdata, 8'h00);
        rx = 1'b1;
        tick(5);
        check("break_exit_busy", busy, 1'b0);
        check("ferr_sticky", frame_err, 1'b1);
        tick(20);
        send_frame(8'h1B, 1'b1, 1'b1, 1'b0);
        tick(20);
        check("recover_rxdata", rxdata, 8'h1B);
        check("recover_ferr", frame_err, 1'b0);

        // Reset during data bit 4 of 0x18 (LSB first: 0,0,0,1,1,...).
        rx = 1'b0;
        tick(Cpb);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 3) ? 1'b1 : 1'b0;
            tick(Cpb);
        end
        rx = 1'b1;
        tick(Cpb / 2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rxdata", rxdata, 8'h00);
        check("midrst_ferr", frame_err, 1'b0);
        tick(50);
        send_frame(8'h19, 1'b1, 1'b1, 1'b0);
        tick(20);
        check("midrst_next", rxdata, 8'h19);

        tick(10);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
